// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
// Opcode values match the funct3 field of the M-extension instructions.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_div(op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic a_signed(op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_signed(op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the shared accumulator: shift-add for multiply,
// shift-subtract-restore for divide ({remainder, quotient} live in acc).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      is_div_i,
    input  logic [2*DATA_WIDTH-1:0]   acc_i,
    input  logic [2*DATA_WIDTH-1:0]   opa_i,
    input  logic [DATA_WIDTH-1:0]     opb_i,
    output logic [2*DATA_WIDTH-1:0]   acc_o,
    output logic [2*DATA_WIDTH-1:0]   opa_o,
    output logic [DATA_WIDTH-1:0]     opb_o
);
    localparam int W = DATA_WIDTH;

    logic [W:0]   remSh;
    logic         geq;
    logic [W-1:0] remSub;

    // The shifted partial remainder can be W+1 bits; its top bit forces a subtract.
    assign remSh  = acc_i[2*W-1:W-1];
    assign geq    = remSh[W] || (remSh[W-1:0] >= opa_i[W-1:0]);
    assign remSub = remSh[W-1:0] - opa_i[W-1:0];

    always_comb begin
        acc_o = acc_i;
        opa_o = opa_i;
        opb_o = opb_i;
        if (is_div_i) begin
            acc_o = geq ? {remSub, acc_i[W-2:0], 1'b1}
                        : {remSh[W-1:0], acc_i[W-2:0], 1'b0};
        end else begin
            if (opb_i[0]) begin
                acc_o = acc_i + opa_i;
            end
            opa_o = {opa_i[2*W-2:0], 1'b0};
            opb_o = {1'b0, opb_i[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready request and response.
// Optional MULDIV_EARLY_OUT_EN ends multiplies once the remaining multiplier bits are zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data
);
    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic               neg_q, neg_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]     acc_q, acc_d;
    logic [2*W-1:0]     opa_q, opa_d;
    logic [W-1:0]       opb_q, opb_d;
    logic [W-1:0]       resp_data_q, resp_data_d;

    op_e          reqOp;
    logic         aNeg, bNeg, divByZero, overflow, lastIter;
    logic [W-1:0] aMag, bMag, specialRes, divPick, divRes, mulRes, finalRes;
    logic [2*W-1:0] stepAcc, stepOpa, prod;
    logic [W-1:0] stepOpb;

    assign reqOp     = op_e'(req_op);
    assign aNeg      = a_signed(reqOp) && req_a[W-1];
    assign bNeg      = b_signed(reqOp) && req_b[W-1];
    assign aMag      = aNeg ? -req_a : req_a;
    assign bMag      = bNeg ? -req_b : req_b;
    assign divByZero = (req_b == '0);
    assign overflow  = b_signed(reqOp) && (req_a == MinNeg) && (req_b == '1);

    // Funct3 bit 1 separates REM/REMU from DIV/DIVU.
    always_comb begin
        specialRes = '0;
        if (divByZero) begin
            specialRes = reqOp[1] ? req_a : '1;
        end else if (overflow) begin
            specialRes = reqOp[1] ? '0 : req_a;
        end
    end

    muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .is_div_i (is_div(op_q)),
        .acc_i    (acc_q),
        .opa_i    (opa_q),
        .opb_i    (opb_q),
        .acc_o    (stepAcc),
        .opa_o    (stepOpa),
        .opb_o    (stepOpb)
    );

    assign prod    = neg_q ? -stepAcc : stepAcc;
    assign mulRes  = (op_q == OP_MUL) ? prod[W-1:0] : prod[2*W-1:W];
    assign divPick = op_q[1] ? stepAcc[2*W-1:W] : stepAcc[W-1:0];
    assign divRes  = neg_q ? -divPick : divPick;
    assign finalRes = is_div(op_q) ? divRes : mulRes;

`ifdef MULDIV_EARLY_OUT_EN
    assign lastIter = (cnt_q == CNT_WIDTH'(W - 1)) || (!is_div(op_q) && (stepOpb == '0));
`else
    assign lastIter = (cnt_q == CNT_WIDTH'(W - 1));
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        resp_data_d = resp_data_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d  = reqOp;
                    neg_d = (is_div(reqOp) && reqOp[1]) ? aNeg : (aNeg ^ bNeg);
                    cnt_d = '0;
                    acc_d = is_div(reqOp) ? {{W{1'b0}}, aMag} : '0;
                    opa_d = {{W{1'b0}}, is_div(reqOp) ? bMag : aMag};
                    opb_d = bMag;
                    if (is_div(reqOp) && (divByZero || overflow)) begin
                        resp_data_d = specialRes;
                        state_d     = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = stepAcc;
                opa_d = stepOpa;
                opb_d = stepOpb;
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (lastIter) begin
                    resp_data_d = finalRes;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_MUL;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: an arithmetic reference model checked every
// response cycle, plus literal expectations, latency, backpressure and reset checks.
module tb_muldiv_unit;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;

    int          checks;
    int          failures;
    logic [31:0] expData;
    bit          chkEn;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result straight from RISC-V M-extension arithmetic rules.
    function automatic logic [31:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic [63:0] pv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = 0;
        case (op)
            MUL:    p = ua * ub;
            MULH:   p = (sa * sb) >>> 32;
            MULHSU: p = (sa * ub) >>> 32;
            MULHU:  p = longint'(64'(ua * ub) >> 32);
            DIV:    p = (b == 0) ? -1 : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? sa : sa / sb);
            DIVU:   p = (b == 0) ? -1 : ua / ub;
            REM:    p = (b == 0) ? sa : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 0 : sa % sb);
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        pv = 64'(p);
        return pv[31:0];
    endfunction

    function automatic int expLat(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        int msb;
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[2]) begin
            msb = 0;
            for (int i = 0; i < 32; i++) if (b[i]) msb = i;
            return 2 + msb;
        end
`endif
        msb = 0;
        return 33 + msb;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && chkEn && resp_valid)
            checkOutput("resp_data vs model", resp_data, expData);
    end

    // Issue one request, measure latency, optionally stall the response for holdCycles.
    task automatic applyStimulus(string name, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                                 bit useLit, logic [31:0] lit, int holdCycles);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " req_ready before issue"}, 32'(req_ready), 32'd1);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        expData   = model(op, a, b);
        chkEn     = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 200);
        checkOutput({name, " latency"}, 32'(n), 32'(expLat(op, a, b)));
        if (useLit)
            checkOutput({name, " literal"}, resp_data, lit);
        checkOutput({name, " req_ready in DONE"}, 32'(req_ready), 32'd0);
        for (int i = 0; i < holdCycles; i++) begin
            req_valid = 1'b1;
            req_op    = MUL;
            req_a     = 32'h0BAD_0000 + 32'(i);
            req_b     = 32'h5;
            @(negedge clk);
            checkOutput({name, " held resp_valid"}, 32'(resp_valid), 32'd1);
            checkOutput({name, " held req_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chkEn      = 1'b0;
        checkOutput({name, " resp_valid after take"}, 32'(resp_valid), 32'd0);
        checkOutput({name, " req_ready after take"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        chkEn      = 1'b0;
        expData    = '0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'b000;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset resp_data", resp_data, 32'd0);
        rst_n = 1'b1;

        applyStimulus("MUL 7*-3",        MUL,    32'd7,          32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 0);
        applyStimulus("MULHU -1*-1",     MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 0);
        applyStimulus("MULH -1*-1",      MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 1, 32'h0000_0000, 0);
        applyStimulus("MULHSU -1*2",     MULHSU, 32'hFFFF_FFFF,  32'd2,         1, 32'hFFFF_FFFF, 0);
        applyStimulus("DIV -7/2",        DIV,    32'hFFFF_FFF9,  32'd2,         1, 32'hFFFF_FFFD, 0);
        applyStimulus("REM -7/2",        REM,    32'hFFFF_FFF9,  32'd2,         1, 32'hFFFF_FFFF, 0);
        applyStimulus("DIVU 100/7",      DIVU,   32'd100,        32'd7,         1, 32'd14,        0);
        applyStimulus("REMU 100/7",      REMU,   32'd100,        32'd7,         1, 32'd2,         0);
        applyStimulus("DIVU 100/0",      DIVU,   32'd100,        32'd0,         1, 32'hFFFF_FFFF, 0);
        applyStimulus("REMU 100/0",      REMU,   32'd100,        32'd0,         1, 32'd100,       0);
        applyStimulus("DIV ovf",         DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1, 32'h8000_0000, 0);
        applyStimulus("REM ovf",         REM,    32'h8000_0000,  32'hFFFF_FFFF, 1, 32'h0000_0000, 0);
        applyStimulus("DIV 100/-7",      DIV,    32'd100,        32'hFFFF_FFF9, 1, 32'hFFFF_FFF2, 0);
        applyStimulus("REM 100/-7",      REM,    32'd100,        32'hFFFF_FFF9, 1, 32'd2,         0);
        applyStimulus("DIV -5/0",        DIV,    32'hFFFF_FFFB,  32'd0,         1, 32'hFFFF_FFFF, 0);
        applyStimulus("REM -5/0",        REM,    32'hFFFF_FFFB,  32'd0,         1, 32'hFFFF_FFFB, 0);
        applyStimulus("MULH min*min",    MULH,   32'h8000_0000,  32'h8000_0000, 1, 32'h4000_0000, 0);
        applyStimulus("MULHSU min*max",  MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 1, 32'h8000_0000, 0);
        applyStimulus("MUL by zero",     MUL,    32'h1234_5678,  32'd0,         1, 32'd0,         0);
        applyStimulus("MUL 5*3",         MUL,    32'd5,          32'd3,         1, 32'd15,        0);
        applyStimulus("DIVU max/1",      DIVU,   32'hFFFF_FFFF,  32'd1,         1, 32'hFFFF_FFFF, 0);
        applyStimulus("MULHU backpress", MULHU,  32'h1234_5678,  32'h9ABC_DEF0, 0, 32'd0,         5);
        applyStimulus("REMU backpress",  REMU,   32'hDEAD_BEEF,  32'd12345,     0, 32'd0,         5);

        // Abort a multiply mid-iteration with an asynchronous reset.
        @(negedge clk);
        req_op    = MUL;
        req_a     = 32'h0001_0001;
        req_b     = 32'h0000_FFFF;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid-CALC reset resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("mid-CALC reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("mid-CALC reset resp_data", resp_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) checkOutput("no response after reset", 32'(resp_valid), 32'd0);
        end
        checkOutput("idle after reset", 32'(req_ready), 32'd1);
        applyStimulus("MUL 3*4 after reset", MUL, 32'd3, 32'd4, 1, 32'd12, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
